chip8_mem_arbiter: RTL and testbench
====================================

CHIP8_MEM_ARBITER -- requirements
Module: chip8_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3, meaning: consecutive denied CPU request cycles before the CPU is promoted over the PPU.
REQ-002 Parameter SCREEN_RAM_OFFSET, default 12'h100, meaning: base of the 256-byte framebuffer; video port addresses are offsets added to it.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 vid_req / vid_addr  input  1 / 8  video scanout read request; offset into the framebuffer.
REQ-006 ppu_req / ppu_we / ppu_addr / ppu_wdata  input  1 / 1 / 12 / 8  PPU access request.
REQ-007 cpu_req / cpu_we / cpu_addr / cpu_wdata  input  1 / 1 / 12 / 8  CPU access request.
REQ-008 vid_gnt, ppu_gnt, cpu_gnt  output  1 each  registered one-cycle accept pulse.
REQ-009 vid_rvalid, ppu_rvalid, cpu_rvalid  output  1 each  registered read-data-valid pulse.
REQ-010 rdata  output  8  read data, routed combinationally from mem_read_data; valid only with an rvalid.
REQ-011 mem_read_address, mem_read_enable, mem_write_address, mem_write_data, mem_write_enable  output  12 / 1 / 12 / 8 / 1  registered RAM port.
REQ-012 mem_read_data  input  8  RAM read data, valid the cycle after mem_read_enable.
REQ-013 cpu_starved  output  1  high while the CPU promotion is in effect.

Function
REQ-014 Arbitration SHALL be evaluated every cycle over eligible requests; eligible = req high and that port's gnt not high this cycle.
REQ-015 Priority SHALL be video > PPU > CPU, except when the starvation counter is >= STARVE_LIMIT: then video > CPU > PPU.
REQ-016 At the edge ending arbitration cycle N, the winner's gnt SHALL be 1 in cycle N+1 and the mem_* outputs SHALL carry its access in cycle N+1.
REQ-017 Grant to a write (we=1) SHALL drive mem_write_enable=1 with the port's address and wdata; mem_read_enable=0.
REQ-018 Grant to a read (video, or we=0) SHALL drive mem_read_enable=1 with the address; the video address SHALL be {4'h0,vid_addr}+SCREEN_RAM_OFFSET.
REQ-019 That port's rvalid SHALL pulse in cycle N+2; writes SHALL produce no rvalid.
REQ-020 With no eligible request, all gnt SHALL be 0 and mem enables, addresses and write data SHALL be 0 next cycle.
REQ-021 Requesters SHALL hold req/addr/we/wdata stable until gnt; a req still high in the gnt cycle is ignored, so at most one access per port per two cycles.
REQ-022 Starvation counter (2 bits min, saturating at STARVE_LIMIT) SHALL increment each cycle cpu_req is eligible and not won, clear when the CPU is granted or cpu_req is low.
REQ-023 cpu_starved SHALL equal (counter >= STARVE_LIMIT), combinational from the register.
REQ-024 Simultaneous requests from all three ports SHALL be served one per cycle in priority order with no idle cycle.
REQ-025 Address arithmetic SHALL be 12-bit and wrap modulo 4096.
REQ-026 Only one of mem_read_enable and mem_write_enable SHALL be high in any cycle.

Reset
REQ-027 While reset_n=0, all gnt, rvalid, mem enables, addresses, write data, cpu_starved and the starvation counter SHALL be 0.
REQ-028 An access granted before reset SHALL produce no rvalid after reset deasserts; the first grant can appear no earlier than the second edge after deassertion.

Structure
REQ-029 Shared package chip8_pkg SHALL hold ADDR_W=12, DATA_W=8, the framebuffer offset, and port index constants PORT_VID=0, PORT_PPU=1, PORT_CPU=2.
REQ-030 The priority pick SHALL be a sub-module chip8_prio_select (3 eligible bits + starve flag in, one-hot winner out); the rvalid routing uses a registered 2-bit owner tag.

Verification
REQ-031 Single CPU read of $200 (RAM holds 8'hA2) -> cpu_gnt in cycle 1, mem_read_address=12'h200 in cycle 1, cpu_rvalid with rdata=8'hA2 in cycle 2.
REQ-032 vid_req(addr 8'h0F), ppu_req, cpu_req raised together -> grants in consecutive cycles video, PPU, CPU; video read address 12'h10F.
REQ-033 PPU requesting continuously with CPU read pending -> after 3 denied cycles cpu_starved=1, CPU granted next, counter clears.
REQ-034 PPU write $105=8'h3C -> mem_write_enable=1, address 12'h105, data 8'h3C for one cycle, no ppu_rvalid.
REQ-035 reset_n pulled low in the cycle after a CPU read grant -> all outputs 0 immediately, no cpu_rvalid after release.
REQ-036 Requester holding req through its gnt cycle -> exactly one grant, next grant no earlier than two cycles later.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 memory arbiter.
//   ADDR_W / DATA_W      : RAM address and data widths
//   SCREEN_RAM_BASE      : default base address of the 256-byte framebuffer
//   PORT_VID/PPU/CPU     : requester indices used for grant vectors and owner tags
package chip8_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] SCREEN_RAM_BASE = 12'h100;

    localparam logic [1:0] PORT_VID = 2'd0;
    localparam logic [1:0] PORT_PPU = 2'd1;
    localparam logic [1:0] PORT_CPU = 2'd2;
endpackage

// File: rtl/chip8_prio_select.sv
// Fixed-priority winner pick for the three memory requesters.
//   elig    : per-port eligible request bits, indexed by PORT_* constants
//   starved : CPU promotion flag; swaps PPU and CPU priority when set
//   win     : one-hot winner (all zero when nothing is eligible)
module chip8_prio_select
    import chip8_pkg::*;
(
    input  logic [2:0] elig,
    input  logic       starved,
    output logic [2:0] win
);

    always_comb begin
        win = '0;
        // Video scanout always comes first; it cannot tolerate latency.
        if (elig[PORT_VID]) begin
            win[PORT_VID] = 1'b1;
        end else if (starved) begin
            if (elig[PORT_CPU]) begin
                win[PORT_CPU] = 1'b1;
            end else if (elig[PORT_PPU]) begin
                win[PORT_PPU] = 1'b1;
            end
        end else begin
            if (elig[PORT_PPU]) begin
                win[PORT_PPU] = 1'b1;
            end else if (elig[PORT_CPU]) begin
                win[PORT_CPU] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Single-port RAM arbiter for video scanout, PPU and CPU.
//   clk, reset_n                   : system clock, async active-low reset
//   vid_req/vid_addr               : framebuffer read, offset from SCREEN_RAM_OFFSET
//   ppu_*, cpu_*                   : general read/write requests
//   *_gnt                          : one-cycle accept pulse, cycle after arbitration
//   *_rvalid, rdata                : read data for the owner, two cycles after arbitration
//   mem_*                          : registered RAM port (read data returns one cycle later)
//   cpu_starved                    : CPU currently promoted above the PPU
module chip8_mem_arbiter
    import chip8_pkg::*;
#(
    parameter int                STARVE_LIMIT      = 3,
    parameter logic [ADDR_W-1:0] SCREEN_RAM_OFFSET = SCREEN_RAM_BASE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [7:0]        vid_addr,
    input  logic              ppu_req,
    input  logic              ppu_we,
    input  logic [ADDR_W-1:0] ppu_addr,
    input  logic [DATA_W-1:0] ppu_wdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              vid_gnt,
    output logic              ppu_gnt,
    output logic              cpu_gnt,
    output logic              vid_rvalid,
    output logic              ppu_rvalid,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              cpu_starved
);

    localparam int CNT_W = (STARVE_LIMIT < 4) ? 2 : $clog2(STARVE_LIMIT + 1);

    logic              armed;
    logic [2:0]        gnt_p1;
    logic [2:0]        rvalid_p2;
    logic              rd_pend_p1;
    logic [1:0]        rd_owner_p1;
    logic [CNT_W-1:0]  starve_cnt;

    logic [2:0]        elig;
    logic [2:0]        win;
    logic              starved;
    logic [CNT_W-1:0]  starve_cnt_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              rd_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;
    logic              wr_en_d;
    logic              rd_pend_d;
    logic [1:0]        rd_owner_d;
    logic [2:0]        rvalid_d;

    // A port is ignored in its own grant cycle, so a held request costs
    // one dead cycle and cannot be granted twice for one access. Nothing is
    // eligible until one edge after reset release.
    always_comb begin
        elig           = '0;
        elig[PORT_VID] = armed & vid_req & ~gnt_p1[PORT_VID];
        elig[PORT_PPU] = armed & ppu_req & ~gnt_p1[PORT_PPU];
        elig[PORT_CPU] = armed & cpu_req & ~gnt_p1[PORT_CPU];
    end

    assign starved = (starve_cnt >= CNT_W'(STARVE_LIMIT));

    chip8_prio_select u_prio (
        .elig    (elig),
        .starved (starved),
        .win     (win)
    );

    always_comb begin
        starve_cnt_d = starve_cnt;
        if (!cpu_req || win[PORT_CPU]) begin
            starve_cnt_d = '0;
        end else if (elig[PORT_CPU] && !starved) begin
            starve_cnt_d = starve_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        rd_addr_d  = '0;
        rd_en_d    = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        wr_en_d    = 1'b0;
        rd_pend_d  = 1'b0;
        rd_owner_d = PORT_VID;
        if (win[PORT_VID]) begin
            rd_en_d    = 1'b1;
            rd_addr_d  = {4'h0, vid_addr} + SCREEN_RAM_OFFSET;
            rd_pend_d  = 1'b1;
            rd_owner_d = PORT_VID;
        end else if (win[PORT_PPU]) begin
            if (ppu_we) begin
                wr_en_d   = 1'b1;
                wr_addr_d = ppu_addr;
                wr_data_d = ppu_wdata;
            end else begin
                rd_en_d    = 1'b1;
                rd_addr_d  = ppu_addr;
                rd_pend_d  = 1'b1;
                rd_owner_d = PORT_PPU;
            end
        end else if (win[PORT_CPU]) begin
            if (cpu_we) begin
                wr_en_d   = 1'b1;
                wr_addr_d = cpu_addr;
                wr_data_d = cpu_wdata;
            end else begin
                rd_en_d    = 1'b1;
                rd_addr_d  = cpu_addr;
                rd_pend_d  = 1'b1;
                rd_owner_d = PORT_CPU;
            end
        end
    end

    always_comb begin
        rvalid_d = '0;
        if (rd_pend_p1) begin
            rvalid_d[rd_owner_p1] = 1'b1;
        end
    end

    // Stage p1: grant and RAM access issued; p2: read data returns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed             <= 1'b0;
            gnt_p1            <= '0;
            rvalid_p2         <= '0;
            rd_pend_p1        <= 1'b0;
            rd_owner_p1       <= PORT_VID;
            starve_cnt        <= '0;
            mem_read_address  <= '0;
            mem_read_enable   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            mem_write_enable  <= 1'b0;
        end else begin
            armed             <= 1'b1;
            gnt_p1            <= win;
            rvalid_p2         <= rvalid_d;
            rd_pend_p1        <= rd_pend_d;
            rd_owner_p1       <= rd_owner_d;
            starve_cnt        <= starve_cnt_d;
            mem_read_address  <= rd_addr_d;
            mem_read_enable   <= rd_en_d;
            mem_write_address <= wr_addr_d;
            mem_write_data    <= wr_data_d;
            mem_write_enable  <= wr_en_d;
        end
    end

    assign vid_gnt     = gnt_p1[PORT_VID];
    assign ppu_gnt     = gnt_p1[PORT_PPU];
    assign cpu_gnt     = gnt_p1[PORT_CPU];
    assign vid_rvalid  = rvalid_p2[PORT_VID];
    assign ppu_rvalid  = rvalid_p2[PORT_PPU];
    assign cpu_rvalid  = rvalid_p2[PORT_CPU];
    assign rdata       = mem_read_data;
    assign cpu_starved = starved;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
module tb_chip8_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vid_req;
    logic [7:0]  vid_addr;
    logic        ppu_req, ppu_we;
    logic [11:0] ppu_addr;
    logic [7:0]  ppu_wdata;
    logic        cpu_req, cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        vid_gnt, ppu_gnt, cpu_gnt;
    logic        vid_rvalid, ppu_rvalid, cpu_rvalid;
    logic [7:0]  rdata;
    logic [11:0] mem_read_address, mem_write_address;
    logic        mem_read_enable, mem_write_enable;
    logic [7:0]  mem_write_data;
    logic [7:0]  mem_read_data = 8'h00;
    logic        cpu_starved;

    logic [7:0]  ram [0:4095];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    chip8_mem_arbiter dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .vid_req           (vid_req),
        .vid_addr          (vid_addr),
        .ppu_req           (ppu_req),
        .ppu_we            (ppu_we),
        .ppu_addr          (ppu_addr),
        .ppu_wdata         (ppu_wdata),
        .cpu_req           (cpu_req),
        .cpu_we            (cpu_we),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .vid_gnt           (vid_gnt),
        .ppu_gnt           (ppu_gnt),
        .cpu_gnt           (cpu_gnt),
        .vid_rvalid        (vid_rvalid),
        .ppu_rvalid        (ppu_rvalid),
        .cpu_rvalid        (cpu_rvalid),
        .rdata             (rdata),
        .mem_read_address  (mem_read_address),
        .mem_read_enable   (mem_read_enable),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_enable  (mem_write_enable),
        .mem_read_data     (mem_read_data),
        .cpu_starved       (cpu_starved)
    );

    // Synchronous RAM: read data appears the cycle after the enable.
    always @(posedge clk) begin
        if (mem_read_enable)  mem_read_data <= ram[mem_read_address];
        if (mem_write_enable) ram[mem_write_address] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vid_req = 0; vid_addr = 0;
        ppu_req = 0; ppu_we = 0; ppu_addr = 0; ppu_wdata = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h200] = 8'hA2;
        ram[12'h201] = 8'h55;
        ram[12'h10F] = 8'h7E;
        ram[12'h0A0] = 8'h19;

        reset_n = 1'b0;
        idle_inputs();
        step();
        step();
        check("rst_gnt",    {vid_gnt, ppu_gnt, cpu_gnt}, 3'b000);
        check("rst_rvalid", {vid_rvalid, ppu_rvalid, cpu_rvalid}, 3'b000);
        check("rst_en",     {mem_read_enable, mem_write_enable}, 2'b00);
        check("rst_addr",   {mem_read_address, mem_write_address, mem_write_data}, 32'h0);
        check("rst_starve", cpu_starved, 1'b0);
        reset_n = 1'b1;
        step();
        step();

        // Single CPU read of $200
        cpu_req = 1; cpu_addr = 12'h200;
        step();
        check("t1_gnt",    {vid_gnt, ppu_gnt, cpu_gnt}, 3'b001);
        check("t1_rden",   {mem_read_enable, mem_write_enable}, 2'b10);
        check("t1_raddr",  mem_read_address, 12'h200);
        cpu_req = 0;
        step();
        check("t1_rvalid", {vid_rvalid, ppu_rvalid, cpu_rvalid}, 3'b001);
        check("t1_rdata",  rdata, 8'hA2);
        check("t1_idle",   {cpu_gnt, mem_read_enable, mem_read_address}, 14'h0);

        // All three ports at once
        vid_req = 1; vid_addr = 8'h0F;
        ppu_req = 1; ppu_addr = 12'h0A0;
        cpu_req = 1; cpu_addr = 12'h201;
        step();
        check("t2_gnt_vid", {vid_gnt, ppu_gnt, cpu_gnt}, 3'b100);
        check("t2_raddr_v", mem_read_address, 12'h10F);
        vid_req = 0;
        step();
        check("t2_gnt_ppu", {vid_gnt, ppu_gnt, cpu_gnt}, 3'b010);
        check("t2_raddr_p", mem_read_address, 12'h0A0);
        check("t2_rv_vid",  {vid_rvalid, ppu_rvalid, cpu_rvalid}, 3'b100);
        check("t2_rd_vid",  rdata, 8'h7E);
        ppu_req = 0;
        step();
        check("t2_gnt_cpu", {vid_gnt, ppu_gnt, cpu_gnt}, 3'b001);
        check("t2_raddr_c", mem_read_address, 12'h201);
        check("t2_rv_ppu",  {vid_rvalid, ppu_rvalid, cpu_rvalid}, 3'b010);
        check("t2_rd_ppu",  rdata, 8'h19);
        cpu_req = 0;
        step();
        check("t2_rv_cpu",  {vid_rvalid, ppu_rvalid, cpu_rvalid}, 3'b001);
        check("t2_rd_cpu",  rdata, 8'h55);

        // Video and PPU alternate; CPU read is starved, then promoted
        vid_req = 1; vid_addr = 8'h00;
        ppu_req = 1; ppu_addr = 12'h0A0;
        cpu_req = 1; cpu_addr = 12'h200;
        step();
        check("t3_c1_gnt", {vid_gnt, ppu_gnt, cpu_gnt}, 3'b100);
        check("t3_c1_stv", cpu_starved, 1'b0);
        step();
        check("t3_c2_gnt", {vid_gnt, ppu_gnt, cpu_gnt}, 3'b010);
        check("t3_c2_stv", cpu_starved, 1'b0);
        step();
        check("t3_c3_gnt", {vid_gnt, ppu_gnt, cpu_gnt}, 3'b100);
        check("t3_c3_stv", cpu_starved, 1'b1);
        step();
        check("t3_c4_gnt", {vid_gnt, ppu_gnt, cpu_gnt}, 3'b001);
        check("t3_c4_stv", cpu_starved, 1'b0);
        idle_inputs();
        step();
        check("t3_rv_cpu", {vid_rvalid, ppu_rvalid, cpu_rvalid}, 3'b001);
        check("t3_rd_cpu", rdata, 8'hA2);
        check("t3_idle",   {vid_gnt, ppu_gnt, cpu_gnt}, 3'b000);

        // PPU write $105 = 3C
        ppu_req = 1; ppu_we = 1; ppu_addr = 12'h105; ppu_wdata = 8'h3C;
        step();
        check("t4_gnt",   {vid_gnt, ppu_gnt, cpu_gnt}, 3'b010);
        check("t4_en",    {mem_read_enable, mem_write_enable}, 2'b01);
        check("t4_waddr", mem_write_address, 12'h105);
        check("t4_wdata", mem_write_data, 8'h3C);
        idle_inputs();
        step();
        check("t4_norv",  {vid_rvalid, ppu_rvalid, cpu_rvalid}, 3'b000);
        check("t4_off",   {mem_write_enable, mem_write_address, mem_write_data}, 21'h0);
        check("t4_ram",   ram[12'h105], 8'h3C);

        // CPU holds its request through and past the grant
        cpu_req = 1; cpu_addr = 12'h200;
        step();
        check("t5_g1", cpu_gnt, 1'b1);
        step();
        check("t5_g2", cpu_gnt, 1'b0);
        check("t5_rv", cpu_rvalid, 1'b1);
        step();
        check("t5_g3", cpu_gnt, 1'b1);
        cpu_req = 0;
        step();
        check("t5_g4", cpu_gnt, 1'b0);
        step();

        // Video offset at the top of the framebuffer
        vid_req = 1; vid_addr = 8'hFF;
        step();
        check("t6_raddr", mem_read_address, 12'h1FF);
        vid_req = 0;
        step();
        step();

        // Reset in the grant cycle of a CPU read
        cpu_req = 1; cpu_addr = 12'h200;
        step();
        check("t7_gnt", cpu_gnt, 1'b1);
        reset_n = 0;
        cpu_req = 0;
        #1;
        check("t7_rst_out", {cpu_gnt, mem_read_enable, mem_read_address}, 14'h0);
        step();
        check("t7_rst_rv", cpu_rvalid, 1'b0);
        reset_n = 1;
        cpu_req = 1;
        step();
        check("t7_edge1_gnt", cpu_gnt, 1'b0);
        check("t7_edge1_rv",  cpu_rvalid, 1'b0);
        step();
        check("t7_edge2_gnt", cpu_gnt, 1'b1);
        cpu_req = 0;
        step();
        check("t7_rv_new", cpu_rvalid, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
